// File: rtl/mux_pkg.sv
// ============================================================================
// Module : mux_pkg
// Brief  : Shared select encoding and type for the 4:1 multiplexer family.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_pkg;

  typedef logic [1:0] mux_sel_t;

  localparam mux_sel_t SEL_IN0 = 2'b00;
  localparam mux_sel_t SEL_IN1 = 2'b01;
  localparam mux_sel_t SEL_IN2 = 2'b10;
  localparam mux_sel_t SEL_IN3 = 2'b11;

endpackage : mux_pkg

`default_nettype wire

// File: rtl/mux_4to1_if.sv
// ============================================================================
// Module : mux_4to1_if
// Brief  : Select/data bundle between a source (master) and the mux (slave).
//          sel_chg exists only when MUX_SEL_STROBE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mux_4to1_if #(
  parameter int WIDTH = 1
);

  mux_pkg::mux_sel_t  sel;
  logic [WIDTH-1:0]   in0;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic [WIDTH-1:0]   in3;
  logic [WIDTH-1:0]   out;
  logic [WIDTH-1:0]   out_q;
`ifdef MUX_SEL_STROBE_EN
  logic               sel_chg;

  modport master (
    output sel, in0, in1, in2, in3,
    input  out, out_q, sel_chg
  );

  modport slave (
    input  sel, in0, in1, in2, in3,
    output out, out_q, sel_chg
  );
`else
  modport master (
    output sel, in0, in1, in2, in3,
    input  out, out_q
  );

  modport slave (
    input  sel, in0, in1, in2, in3,
    output out, out_q
  );
`endif

endinterface : mux_4to1_if

`default_nettype wire

// File: rtl/mux4_slice.sv
// ============================================================================
// Module : mux4_slice
// Brief  : Purely combinational WIDTH-bit 4:1 selection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux4_slice
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  mux_sel_t         i_sel,
  input  logic [WIDTH-1:0] i_in0,
  input  logic [WIDTH-1:0] i_in1,
  input  logic [WIDTH-1:0] i_in2,
  input  logic [WIDTH-1:0] i_in3,
  output logic [WIDTH-1:0] o_out
);

  // An unknown select yields X so bad upstream control is visible in simulation.
  always_comb begin
    o_out = 'x;
    case (i_sel)
      SEL_IN0: o_out = i_in0;
      SEL_IN1: o_out = i_in1;
      SEL_IN2: o_out = i_in2;
      SEL_IN3: o_out = i_in3;
      default: o_out = 'x;
    endcase
  end

endmodule : mux4_slice

`default_nettype wire

// File: rtl/mux_4to1.sv
// ============================================================================
// Module : mux_4to1
// Brief  : 4:1 mux with combinational and registered outputs; the select-change
//          strobe sel_chg is built only when MUX_SEL_STROBE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_4to1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  mux_4to1_if.slave        bus
);

  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] r_out_q;

  mux4_slice #(
    .WIDTH (WIDTH)
  ) u_slice (
    .i_sel (bus.sel),
    .i_in0 (bus.in0),
    .i_in1 (bus.in1),
    .i_in2 (bus.in2),
    .i_in3 (bus.in3),
    .o_out (w_out)
  );

  assign bus.out = w_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_q <= '0;
    end else begin
      r_out_q <= w_out;
    end
  end

  assign bus.out_q = r_out_q;

`ifdef MUX_SEL_STROBE_EN
  mux_sel_t r_sel_q;
  logic     r_sel_chg;

  // Reset value SEL_IN0 makes the first edge with a non-zero select pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_q   <= SEL_IN0;
      r_sel_chg <= 1'b0;
    end else begin
      r_sel_chg <= (bus.sel != r_sel_q);
      r_sel_q   <= bus.sel;
    end
  end

  assign bus.sel_chg = r_sel_chg;
`endif

endmodule : mux_4to1

`default_nettype wire

// File: tb/tb_mux_4to1.sv
// ============================================================================
// Module : tb_mux_4to1
// Brief  : Directed and randomized checks of mux_4to1 at WIDTH=1 and WIDTH=8.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_4to1;

  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  mux_4to1_if #(.WIDTH(1)) bus1 ();
  mux_4to1_if #(.WIDTH(8)) bus8 ();

  mux_4to1 #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mux_4to1 #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the output is simply the array element addressed by sel.
  function automatic logic [7:0] ref_mux(input logic [1:0] s, input logic [7:0] d [4]);
    return d[s];
  endfunction

  task automatic tick();
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #5;
  endtask

  task automatic drive1(input logic [1:0] s, input logic [3:0] v);
    bus1.sel = s;
    bus1.in0 = v[0];
    bus1.in1 = v[1];
    bus1.in2 = v[2];
    bus1.in3 = v[3];
  endtask

  task automatic drive8(input logic [1:0] s, input logic [7:0] d [4]);
    bus8.sel = s;
    bus8.in0 = d[0];
    bus8.in1 = d[1];
    bus8.in2 = d[2];
    bus8.in3 = d[3];
  endtask

  logic [7:0] data [4];
  logic [7:0] exp_q;
  logic [1:0] s;
  logic [3:0] pat;

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    drive1(2'b00, 4'b0000);
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    drive8(2'b00, data);
    #1;
    check("reset_out_q_w1", 32'(bus1.out_q), 32'h0);
    check("reset_out_q_w8", 32'(bus8.out_q), 32'h0);
    // combinational path works while reset is held and clk idle
    drive1(2'b10, 4'b0100);
    #1;
    check("out_during_rst", 32'(bus1.out), 32'h1);

    rst = 1'b0;
    // one-hot select, then inverted pattern
    for (int i = 0; i < 4; i++) begin
      s   = 2'(i);
      pat = 4'b0001 << i;
      drive1(s, pat);
      #10;
      check($sformatf("onehot_sel%0d", i), 32'(bus1.out), 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      s   = 2'(i);
      pat = ~(4'b0001 << i);
      drive1(s, pat);
      #10;
      check($sformatf("inverted_sel%0d", i), 32'(bus1.out), 32'h0);
    end

    // input isolation: in2 held at 1, others toggle
    for (int i = 0; i < 8; i++) begin
      pat = 4'(i);
      drive1(2'b10, {pat[2], 1'b1, pat[1], pat[0]});
      #10;
      check($sformatf("isolation_%0d", i), 32'(bus1.out), 32'h1);
    end

    // register and asynchronous reset
    rst = 1'b1;
    #1;
    check("rst_async_out_q", 32'(bus1.out_q), 32'h0);
    rst = 1'b0;
    drive1(2'b11, 4'b1000);
    #4;
    check("out_q_before_edge", 32'(bus1.out_q), 32'h0);
    tick();
    check("out_q_after_edge", 32'(bus1.out_q), 32'h1);
    rst = 1'b1;
    #1;
    check("midop_rst_out_q", 32'(bus1.out_q), 32'h0);
    check("midop_rst_out", 32'(bus1.out), 32'h1);
    rst = 1'b0;
    #4;

    // WIDTH=8 sweep with fixed data
    data[0] = 8'hA5; data[1] = 8'h3C; data[2] = 8'hFF; data[3] = 8'h00;
    exp_q = 8'h00;
    for (int i = 0; i < 4; i++) begin
      drive8(2'(i), data);
      #1;
      check($sformatf("w8_out_sel%0d", i), 32'(bus8.out), 32'(ref_mux(2'(i), data)));
      check($sformatf("w8_out_q_hold%0d", i), 32'(bus8.out_q), 32'(exp_q));
      #3;
      exp_q = ref_mux(2'(i), data);
      tick();
      check($sformatf("w8_out_q_sel%0d", i), 32'(bus8.out_q), 32'(exp_q));
    end

    // randomized traffic with occasional reset between edges
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
      s = 2'($urandom_range(0, 3));
      drive8(s, data);
      #1;
      check("rand_out", 32'(bus8.out), 32'(ref_mux(s, data)));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        #1;
        check("rand_rst_out_q", 32'(bus8.out_q), 32'h0);
        check("rand_rst_out", 32'(bus8.out), 32'(ref_mux(s, data)));
        rst = 1'b0;
      end
      #2;
      exp_q = ref_mux(s, data);
      tick();
      check("rand_out_q", 32'(bus8.out_q), 32'(exp_q));
    end

`ifdef MUX_SEL_STROBE_EN
    rst = 1'b1;
    #1;
    check("strobe_rst", 32'(bus8.sel_chg), 32'h0);
    rst = 1'b0;
    bus8.sel = 2'b01;
    #4;
    tick();
    check("strobe_first_edge", 32'(bus8.sel_chg), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("strobe_held_%0d", i), 32'(bus8.sel_chg), 32'h0);
    end
    bus8.sel = 2'b10;
    tick();
    check("strobe_change", 32'(bus8.sel_chg), 32'h1);
    tick();
    check("strobe_one_cycle", 32'(bus8.sel_chg), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mux_4to1

`default_nettype wire
